timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shares one tick-count timer among several requesters (cursor-move, debounce, blink sources in the etch-a-sketch datapath). Each requester asks for a delay of a programmable number of enabled ticks. A round-robin arbiter grants the timer to one requester at a time, runs the count, and pulses that requester's `done` when the delay expires. It replaces per-requester pulse generators where only one delay needs to be active at a time.

## Interface
Parameters:
- `N`, 8, width of each tick count
- `REQ`, 4, number of requesters (2..8)

Ports:
- `clk`  in  1  system clock; single clock domain, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ena`  in  1  tick enable; the counter advances only when high
- `req`  in  REQ  level request per requester; held high until `done` or abort
- `ticks`  in  REQ*N  flattened delay per requester; slice i is `ticks[i*N +: N]`
- `gnt`  out  REQ  registered one-hot grant; all zero when idle
- `done`  out  REQ  registered one-cycle completion pulse to the owning requester
- `busy`  out  1  high whenever state is not IDLE
- `active_id`  out  $clog2(REQ)  index of the current or last granted requester

## Operation
- States: IDLE, RUN, DONE.
- IDLE, no `req` bit set: stay in IDLE.
- IDLE, any `req` bit set: pick the first set bit at or after `ptr`, wrapping around. Next cycle: RUN, `gnt[id]`=1, `active_id`=id, `count`=0, `limit` latched from that requester's `ticks` slice.
- `limit` is fixed for the whole grant. Later changes to `ticks` are ignored until the next grant.
- `ticks`==0 is treated as 1.
- RUN, `ena`=1 and `count`==`limit`-1: next state DONE.
- RUN, `ena`=1, otherwise: `count` += 1.
- RUN, `ena`=0: `count` holds.
- DONE: for this one cycle, `done[id]`=1, `gnt`=0 and `ptr`=id+1 (mod REQ). Next state IDLE.
- A requester whose `req` is still high after its `done` re-enters arbitration behind the others.
- `count` and `limit` are N bits wide; the compare is unsigned. Max delay is 2^N-1 ticks.
- Simultaneous `req` bits: pure round-robin from `ptr`; no fixed priority.
- `req` bits of non-owners may change freely during RUN; they have no effect until IDLE.

## Timing
- Reset (asynchronous, immediate, including mid-RUN): state=IDLE, `gnt`=0, `done`=0, `busy`=0, `active_id`=0, `ptr`=0, `count`=0, `limit`=0. No `done` is produced for an interrupted grant.
- `req` first seen in IDLE at cycle c: `gnt` and `busy` rise at c+1.
- With `ena` held at 1 and delay T, `done` fires at c+T+1. Each cycle with `ena`=0 during RUN adds one cycle.
- `gnt` falls in the same cycle `done` rises. `busy` stays high through DONE and falls at c+T+2.
- The earliest next grant is at c+T+3. Throughput is one grant per T+2 cycles.

## Configuration
- `TIMER_ARBITER_ABORT_EN` defined:
  - In RUN, if `req[active_id]` is low, the next state is IDLE.
  - `gnt`=0, no `done` pulse, `ptr`=active_id+1.
  - This is evaluated before the expiry compare: a drop in the expiry cycle aborts.
- Not defined: `req` is ignored after the grant. The count always completes and `done` is always pulsed.

## Structure
- Package `timer_arbiter_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DONE);
  - the default `REQ` and `N` constants;
  - a helper function for the index width.
- Sub-module `rr_arbiter`: combinational, takes `req` and `ptr`, returns the one-hot pick and its index. Reusable by other shared resources.
- `timer_arbiter` holds the FSM, `ptr`, `count`, `limit` and the output registers.

## Test plan
- Reset, then `req`=0001 with ticks0=3 and `ena`=1 at cycle 0 -> `gnt`=0001 at cycles 1-3, `done`=0001 at cycle 4, `busy` low at cycle 5.
- `req`=1111 held, all ticks=1 -> grants in order 0,1,2,3,0 with every `done` 3 cycles apart.
- ticks0=2, `ena` low for 2 cycles mid-RUN -> `done` delayed by exactly 2 cycles. ticks0=0 behaves exactly as ticks0=1.
- `rst` pulsed mid-RUN (count=5, ticks=10) -> all outputs 0 at once. After release with `req` held, a fresh grant starts from `ptr`=0 and count=0.
- Macro defined: `req[2]` dropped at count=3 of 8 -> no `done[2]`, IDLE next cycle, next grant goes to requester 3.
- Macro undefined, same stimulus -> `done[2]` pulses at full expiry.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter: FSM state type, default sizes
// and the index-width helper used for requester numbers.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_REQ = 4;
    localparam int DEFAULT_N   = 8;

    // Bits needed to number 'count' requesters; never less than one bit.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// around, and returns the first set bit as a one-hot vector and an index.
// Kept generic so other shared resources can reuse it.
module rr_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int REQ = DEFAULT_REQ,
    parameter int IW  = index_width(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [REQ-1:0] pick,
    output logic [IW-1:0]  pick_id,
    output logic           pick_valid
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk the requesters in rotated order and keep only the first hit.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < REQ; k++) begin
            idx = IW'((int'(ptr) + k) % REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_id   = idx;
            end
        end
    end

    assign pick_valid = |req;

endmodule

// File: rtl/timer_arbiter.sv
// Shared tick-count timer handed out round-robin to several requesters.
// The owner's delay is latched at grant time, counted on enabled ticks, and
// a one-cycle done pulse is returned to that owner when it expires.
// Optional build macro TIMER_ARBITER_ABORT_EN: the owner dropping its
// request during the count cancels the grant without a done pulse.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int REQ = DEFAULT_REQ
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [REQ-1:0]               req,
    input  logic [REQ*N-1:0]             ticks,
    output logic [REQ-1:0]               gnt,
    output logic [REQ-1:0]               done,
    output logic                         busy,
    output logic [index_width(REQ)-1:0]  active_id
);

    localparam int IW = index_width(REQ);

    state_t         state;
    state_t         state_n;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_n;
    logic [IW-1:0]  active_id_n;
    logic [REQ-1:0] gnt_n;
    logic [REQ-1:0] done_n;
    logic [N-1:0]   count;
    logic [N-1:0]   count_n;
    logic [N-1:0]   limit;
    logic [N-1:0]   limit_n;
    logic [N-1:0]   pick_ticks;
    logic [REQ-1:0] pick;
    logic [IW-1:0]  pick_id;
    logic           pick_valid;
    logic           abort;

    // Requester after 'id', wrapping at REQ; used to rotate fairness.
    function automatic logic [IW-1:0] next_index(input logic [IW-1:0] id);
        return (int'(id) == REQ - 1) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .REQ(REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (ptr),
        .pick      (pick),
        .pick_id   (pick_id),
        .pick_valid(pick_valid)
    );

    assign pick_ticks = ticks[int'(pick_id)*N +: N];
    assign busy       = (state != IDLE);

    // Next-state and next-register logic; a zero delay is stretched to one
    // tick so the compare against limit-1 never underflows.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        count_n     = count;
        limit_n     = limit;
        gnt_n       = gnt;
        done_n      = '0;
        active_id_n = active_id;
        abort       = 1'b0;
`ifdef TIMER_ARBITER_ABORT_EN
        abort       = !req[active_id];
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n     = RUN;
                    gnt_n       = pick;
                    active_id_n = pick_id;
                    count_n     = '0;
                    limit_n     = (pick_ticks == '0) ? N'(1) : pick_ticks;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = next_index(active_id);
                end else if (ena) begin
                    if (count == limit - 1'b1) begin
                        state_n = DONE;
                        gnt_n   = '0;
                        done_n  = gnt;
                        ptr_n   = next_index(active_id);
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State register; reset drops any grant in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            limit     <= '0;
            gnt       <= '0;
            done      <= '0;
            active_id <= '0;
        end else begin
            ptr       <= ptr_n;
            count     <= count_n;
            limit     <= limit_n;
            gnt       <= gnt_n;
            done      <= done_n;
            active_id <= active_id_n;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: constant vector table, directed
// multi-cycle sequences and randomized traffic against a countdown model.
// Honors TIMER_ARBITER_ABORT_EN when the design is built with it.
module tb_timer_arbiter;

    localparam int REQ = 4;
    localparam int N   = 8;

`ifdef TIMER_ARBITER_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] ticks;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  active_id;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the timer, how many enabled ticks remain,
    // whether this is the completion cycle, and the rotation start point.
    int m_owner    = -1;
    int m_left     = 0;
    bit m_done_now = 1'b0;
    int m_ptr      = 0;
    int m_last     = 0;

    typedef struct {
        logic       rst;
        logic       ena;
        logic [3:0] req;
        logic [7:0] tick0;
        logic [3:0] exp_gnt;
        logic [3:0] exp_done;
        logic       exp_busy;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs[15];
    int   rr_order[5] = '{0, 1, 2, 3, 0};

    logic        rnd_rst;
    logic        rnd_ena;
    logic [3:0]  rnd_req;
    logic [31:0] tk;
    int          n_done;
    int          last_cycle;
    int          found_id;
    int          done_at;
    int          done2_at;
    int          gnt3_at;

    always #5 clk = ~clk;

    timer_arbiter #(
        .N  (N),
        .REQ(REQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .req      (req),
        .ticks    (ticks),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .active_id(active_id)
    );

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        if (rst) begin
            m_owner    = -1;
            m_left     = 0;
            m_done_now = 1'b0;
            m_ptr      = 0;
            m_last     = 0;
        end else if (m_done_now) begin
            m_done_now = 1'b0;
        end else if (m_owner >= 0) begin
            if (ABORT_EN && !req[m_owner]) begin
                m_ptr   = (m_owner + 1) % REQ;
                m_owner = -1;
            end else if (ena) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done_now = 1'b1;
                    m_ptr      = (m_owner + 1) % REQ;
                    m_owner    = -1;
                end
            end
        end else if (req != 4'b0) begin
            for (int k = 0; k < REQ; k++) begin
                int i = (m_ptr + k) % REQ;
                if (req[i]) begin
                    m_owner = i;
                    break;
                end
            end
            m_last = m_owner;
            m_left = int'(ticks[m_owner*N +: N]);
            if (m_left == 0) m_left = 1;
        end
    endtask

    // Drive inputs, take one clock edge, and settle just after it.
    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [3:0] rq, input logic [31:0] tk_in);
        rst   = r;
        ena   = e;
        req   = rq;
        ticks = tk_in;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_gnt,
                               input logic [3:0] exp_done, input logic exp_busy,
                               input logic [1:0] exp_id);
        checks++;
        if ({gnt, done, busy, active_id} !== {exp_gnt, exp_done, exp_busy, exp_id}) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b done=%b busy=%b id=%0d, expected gnt=%b done=%b busy=%b id=%0d",
                     name, gnt, done, busy, active_id, exp_gnt, exp_done, exp_busy, exp_id);
        end
    endtask

    task automatic check_value(input string name, input int got, input int expected);
        checks++;
        if (got != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0] eg;
        logic [3:0] ed;
        eg = (m_owner >= 0) ? onehot(m_owner) : 4'b0;
        ed = m_done_now ? onehot(m_last) : 4'b0;
        checkOutput(name, eg, ed, (m_owner >= 0) || m_done_now, 2'(m_last));
    endtask

    initial begin
        rst   = 1'b1;
        ena   = 1'b0;
        req   = 4'b0;
        ticks = 32'b0;
        rnd_req = 4'b0;

        // rst ena req tick0 | gnt done busy id
        vecs[0]  = '{1'b1, 1'b1, 4'b0000, 8'd0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[4]  = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, 8'd3, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 4'b0001, 8'd0, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[7]  = '{1'b0, 1'b1, 4'b0001, 8'd0, 4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[8]  = '{1'b0, 1'b1, 4'b0000, 8'd0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 4'b0001, 8'd2, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 4'b0001, 8'd2, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 4'b0001, 8'd2, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[12] = '{1'b0, 1'b1, 4'b0001, 8'd2, 4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 1'b1, 4'b0001, 8'd2, 4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[14] = '{1'b0, 1'b1, 4'b0000, 8'd2, 4'b0000, 4'b0000, 1'b0, 2'd0};

        // Single requester: delay 3, delay 0 as 1, delay 2 with a 2-cycle stall.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ena, vecs[i].req, {24'd0, vecs[i].tick0});
            checkOutput($sformatf("vector %0d", i), vecs[i].exp_gnt, vecs[i].exp_done,
                        vecs[i].exp_busy, vecs[i].exp_id);
        end

        // All four requesting with delay 1: strict rotation, done every 3 cycles.
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'b0);
        check_model("rr reset");
        tk = 32'h01010101;
        n_done = 0;
        last_cycle = 0;
        for (int cyc = 0; cyc < 40 && n_done < 5; cyc++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, tk);
            check_model("rr cycle");
            if (done != 4'b0) begin
                found_id = -1;
                for (int b = 0; b < REQ; b++) if (done[b]) found_id = b;
                check_value("rr order", found_id, rr_order[n_done]);
                if (n_done > 0) check_value("rr spacing", cyc - last_cycle, 3);
                last_cycle = cyc;
                n_done++;
            end
        end
        check_value("rr done count", n_done, 5);

        // Next grant rotates to requester 1; reset it asynchronously at count 5.
        tk = 32'h0A0A0A0A;
        applyStimulus(1'b0, 1'b1, 4'b1111, tk);
        check_model("rr gap");
        applyStimulus(1'b0, 1'b1, 4'b1111, tk);
        checkOutput("grant before reset", 4'b0010, 4'b0000, 1'b1, 2'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, tk);
            check_model("run before reset");
        end
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset mid run", 4'b0000, 4'b0000, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b1, 4'b1111, tk);
        check_model("held reset");
        applyStimulus(1'b0, 1'b1, 4'b1111, tk);
        checkOutput("fresh grant after reset", 4'b0001, 4'b0000, 1'b1, 2'd0);
        done_at = -1;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, tk);
            check_model("fresh grant run");
            if (done != 4'b0 && done_at < 0) done_at = k;
        end
        check_value("fresh grant done latency", done_at, 10);

        // Requester 2 drops its request at count 3 of 8 while 3 waits.
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'b0);
        check_model("drop reset");
        tk = 32'h00080000;
        applyStimulus(1'b0, 1'b1, 4'b0100, tk);
        checkOutput("drop grant", 4'b0100, 4'b0000, 1'b1, 2'd2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b1100, tk);
            check_model("drop run");
        end
        done2_at = -1;
        gnt3_at  = -1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b1000, tk);
            check_model("drop tail");
            if (done[2] && done2_at < 0) done2_at = k;
            if (gnt[3] && gnt3_at < 0) gnt3_at = k;
        end
`ifdef TIMER_ARBITER_ABORT_EN
        check_value("abort no done2", done2_at, -1);
        check_value("abort next grant", gnt3_at, 1);
`else
        check_value("no abort done2", done2_at, 4);
        check_value("no abort next grant", gnt3_at, 6);
`endif

        // Random traffic with occasional resets, checked every cycle.
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'b0);
        check_model("random reset");
        tk = 32'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rnd_rst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < REQ; b++) begin
                if ($urandom_range(0, 7) == 0) rnd_req[b] = ~rnd_req[b];
            end
            rnd_ena = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < REQ; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tk[s*N +: N] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                                : 8'($urandom_range(0, 4));
                end
            end
            applyStimulus(rnd_rst, rnd_ena, rnd_req, tk);
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
